alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 186 ++++++++++++++++++
 tb/tb_alu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU.
//   aluinst_t : 5-bit operation select, byte operations first, then word operations.
//   BYTE_W / WORD_W : active widths of byte and word operations.
//   is_word_op() : true for the operations that work on the full 16 bits.
package alu_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [4:0] {
    ADD, ADC, SUB, SBC, OR, AND, XOR, SRL, SLL, RRC, RLC, INC, DEC, CLR, PASS0,
    SUBW, SBCW, ADDW, ADCW, ADSW, SEX, PASSW0
  } aluinst_t;

  // Encodings past PASSW0 are undefined and fall back to a byte PASS0,
  // so only the defined word range counts as a word operation.
  function automatic logic is_word_op(input aluinst_t inst);
    return (inst >= SUBW) && (inst <= PASSW0);
  endfunction

endpackage

// File: rtl/alu.sv
// alu: 8/16-bit integer ALU with carry/borrow, zero and negative flags.
// Latency: 0 cycles by default; 1 cycle when ALU_OUTREG_EN is defined.
// Backpressure: none, a new operation is accepted on every cycle.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset (registered build only)
//   aluinst           operation select (aluinst_t)
//   op0, op1          operands; byte operations look at [7:0] only
//   op2, accsel_in    reserved, ignored
//   c_in              carry/borrow in
//   swapop_in         exchange op0 and op1 before the operation
//   result_reg        raw 16-bit result (upper byte zero for byte operations)
//   result_mem        write-back data (zero-extended low byte for byte operations)
//   c_out/z_out/n_out carry/borrow, zero and negative flags
// Build option: define ALU_OUTREG_EN to register every output.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  aluinst_t    aluinst,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic [1:0]  accsel_in,
  input  logic        c_in,
  input  logic        swapop_in,
  output logic [15:0] result_reg,
  output logic [15:0] result_mem,
  output logic        c_out,
  output logic        z_out,
  output logic        n_out
);

  logic [15:0] a;
  logic [15:0] b;
  logic        word;
  logic [8:0]  sum9;
  logic [16:0] sum17;
  logic [15:0] res_d;
  logic [15:0] mem_d;
  logic        c_d;
  logic        z_d;
  logic        n_d;

  assign a    = swapop_in ? op1 : op0;
  assign b    = swapop_in ? op0 : op1;
  assign word = is_word_op(aluinst);

  // Arithmetic is done one bit wider than the operation, so the extra bit is
  // the carry for additions and the borrow for subtractions (two's complement).
  // Byte operations touch only a[7:0]/b[7:0], which keeps the upper operand
  // bits (possibly X) out of every byte result and flag.
  always_comb begin
    sum9  = 9'h000;
    sum17 = 17'h00000;
    res_d = 16'h0000;
    c_d   = 1'b0;
    case (aluinst)
      ADD: begin
        sum9       = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        res_d[7:0] = sum9[7:0];
        c_d        = sum9[8];
      end
      ADC: begin
        sum9       = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, c_in};
        res_d[7:0] = sum9[7:0];
        c_d        = sum9[8];
      end
      SUB: begin
        sum9       = {1'b0, a[7:0]} - {1'b0, b[7:0]};
        res_d[7:0] = sum9[7:0];
        c_d        = sum9[8];
      end
      SBC: begin
        sum9       = {1'b0, a[7:0]} - {1'b0, b[7:0]} - {8'h00, c_in};
        res_d[7:0] = sum9[7:0];
        c_d        = sum9[8];
      end
      OR:  res_d[7:0] = a[7:0] | b[7:0];
      AND: res_d[7:0] = a[7:0] & b[7:0];
      XOR: res_d[7:0] = a[7:0] ^ b[7:0];
      SRL: begin
        res_d[7:0] = {1'b0, a[7:1]};
        c_d        = a[0];
      end
      SLL: begin
        res_d[7:0] = {a[6:0], 1'b0};
        c_d        = a[7];
      end
      RRC: begin
        res_d[7:0] = {c_in, a[7:1]};
        c_d        = a[0];
      end
      RLC: begin
        res_d[7:0] = {a[6:0], c_in};
        c_d        = a[7];
      end
      INC: begin
        sum9       = {1'b0, a[7:0]} + 9'h001;
        res_d[7:0] = sum9[7:0];
        c_d        = sum9[8];
      end
      DEC: begin
        sum9       = {1'b0, a[7:0]} - 9'h001;
        res_d[7:0] = sum9[7:0];
        c_d        = sum9[8];
      end
      CLR: res_d = 16'h0000;
      SUBW: begin
        sum17 = {1'b0, a} - {1'b0, b};
        res_d = sum17[15:0];
        c_d   = sum17[16];
      end
      SBCW: begin
        sum17 = {1'b0, a} - {1'b0, b} - {16'h0000, c_in};
        res_d = sum17[15:0];
        c_d   = sum17[16];
      end
      ADDW: begin
        sum17 = {1'b0, a} + {1'b0, b};
        res_d = sum17[15:0];
        c_d   = sum17[16];
      end
      ADCW: begin
        sum17 = {1'b0, a} + {1'b0, b} + {16'h0000, c_in};
        res_d = sum17[15:0];
        c_d   = sum17[16];
      end
      ADSW: begin
        // Signed byte offset added to a word; carry is still the unsigned bit-16 carry.
        sum17 = {1'b0, a} + {1'b0, {8{b[7]}}, b[7:0]};
        res_d = sum17[15:0];
        c_d   = sum17[16];
      end
      SEX:    res_d = {{8{a[7]}}, a[7:0]};
      PASSW0: res_d = a;
      // PASS0 and every undefined encoding.
      default: res_d[7:0] = a[7:0];
    endcase
  end

  always_comb begin
    if (word) begin
      mem_d = res_d;
      z_d   = (res_d == 16'h0000);
      n_d   = res_d[15];
    end else begin
      mem_d = {8'h00, res_d[7:0]};
      z_d   = (res_d[7:0] == 8'h00);
      n_d   = res_d[7];
    end
  end

`ifdef ALU_OUTREG_EN
  logic unused_ok;
  assign unused_ok = ^{op2, accsel_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg <= 16'h0000;
      result_mem <= 16'h0000;
      c_out      <= 1'b0;
      z_out      <= 1'b0;
      n_out      <= 1'b0;
    end else begin
      result_reg <= res_d;
      result_mem <= mem_d;
      c_out      <= c_d;
      z_out      <= z_d;
      n_out      <= n_d;
    end
  end
`else
  // Purely combinational build: clock and reset are not used.
  logic unused_ok;
  assign unused_ok = ^{op2, accsel_in, clk, reset};

  assign result_reg = res_d;
  assign result_mem = mem_d;
  assign c_out      = c_d;
  assign z_out      = z_d;
  assign n_out      = n_d;
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random checks of alu against an arithmetic reference model.
// Works with either build; ALU_OUTREG_EN selects 1-cycle sampling and reset tests.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  aluinst_t    aluinst;
  logic [15:0] op0;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [1:0]  accsel_in;
  logic        c_in;
  logic        swapop_in;
  logic [15:0] result_reg;
  logic [15:0] result_mem;
  logic        c_out;
  logic        z_out;
  logic        n_out;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk       (clk),
    .reset     (reset),
    .aluinst   (aluinst),
    .op0       (op0),
    .op1       (op1),
    .op2       (op2),
    .accsel_in (accsel_in),
    .c_in      (c_in),
    .swapop_in (swapop_in),
    .result_reg(result_reg),
    .result_mem(result_mem),
    .c_out     (c_out),
    .z_out     (z_out),
    .n_out     (n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic straight from the operation definitions.
  function automatic void ref_alu(input int inst, input int o0, input int o1,
                                  input int cin, input int swap,
                                  output int res, output int mem,
                                  output int c, output int z, output int n);
    int a, b, v, w, sb;
    a = swap ? o1 : o0;
    b = swap ? o0 : o1;
    w = 8; res = 0; c = 0;
    case (inst)
      ADD:  begin v = (a & 255) + (b & 255);       res = v & 255; c = (v > 255); end
      ADC:  begin v = (a & 255) + (b & 255) + cin; res = v & 255; c = (v > 255); end
      SUB:  begin v = (a & 255) - (b & 255);       res = v & 255; c = (v < 0);   end
      SBC:  begin v = (a & 255) - (b & 255) - cin; res = v & 255; c = (v < 0);   end
      OR:   res = (a | b) & 255;
      AND:  res = (a & b) & 255;
      XOR:  res = (a ^ b) & 255;
      SRL:  begin res = (a & 255) >> 1;               c = a & 1;        end
      SLL:  begin res = (a << 1) & 255;               c = (a >> 7) & 1; end
      RRC:  begin res = (cin << 7) | ((a & 255) >> 1); c = a & 1;       end
      RLC:  begin res = ((a << 1) & 255) | cin;       c = (a >> 7) & 1; end
      INC:  begin v = (a & 255) + 1; res = v & 255; c = (v > 255); end
      DEC:  begin v = (a & 255) - 1; res = v & 255; c = (v < 0);   end
      CLR:  res = 0;
      SUBW: begin w = 16; v = a - b;       res = v & 65535; c = (v < 0);     end
      SBCW: begin w = 16; v = a - b - cin; res = v & 65535; c = (v < 0);     end
      ADDW: begin w = 16; v = a + b;       res = v & 65535; c = (v > 65535); end
      ADCW: begin w = 16; v = a + b + cin; res = v & 65535; c = (v > 65535); end
      ADSW: begin
        w  = 16;
        sb = ((b & 255) >= 128) ? (b & 255) + 65280 : (b & 255);
        v  = a + sb; res = v & 65535; c = (v > 65535);
      end
      SEX:    begin w = 16; res = ((a & 128) != 0) ? ((a & 255) | 65280) : (a & 255); end
      PASSW0: begin w = 16; res = a; end
      default: res = a & 255;
    endcase
    mem = (w == 8) ? (res & 255) : res;
    z   = ((res & ((1 << w) - 1)) == 0);
    n   = (res >> (w - 1)) & 1;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] er, input logic [15:0] em,
                         input logic ec, input logic ez, input logic en);
    chk({tag, ".reg"}, result_reg, er);
    chk({tag, ".mem"}, result_mem, em);
    chk({tag, ".c"}, {15'h0, c_out}, {15'h0, ec});
    chk({tag, ".z"}, {15'h0, z_out}, {15'h0, ez});
    chk({tag, ".n"}, {15'h0, n_out}, {15'h0, en});
  endtask

  // Drive one operation and wait until its result is visible on the outputs.
  task automatic apply(input aluinst_t inst, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic swap);
    aluinst   = inst;
    op0       = a;
    op1       = b;
    c_in      = cin;
    swapop_in = swap;
    op2       = 16'($urandom);
    accsel_in = 2'($urandom);
`ifdef ALU_OUTREG_EN
    @(posedge clk);
`endif
    #1;
  endtask

  task automatic apply_model(input string tag, input aluinst_t inst, input logic [15:0] a,
                             input logic [15:0] b, input logic cin, input logic swap);
    int r, m, c, z, n;
    apply(inst, a, b, cin, swap);
    ref_alu(int'(inst), int'(a), int'(b), int'(cin), int'(swap), r, m, c, z, n);
    chk_all(tag, 16'(r), 16'(m), 1'(c), 1'(z), 1'(n));
  endtask

  initial begin
    aluinst   = ADD;
    op0       = 16'h0003;
    op1       = 16'h0004;
    op2       = 16'h0000;
    accsel_in = 2'b00;
    c_in      = 1'b0;
    swapop_in = 1'b0;
    reset     = 1'b1;

`ifdef ALU_OUTREG_EN
    #1;
    chk_all("reset_state", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_held", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
`else
    #1;
    chk_all("reset_ignored", 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
`endif

    apply(ADD, 16'h0080, 16'h0080, 1'b0, 1'b0);
    chk_all("add_80_80", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    apply(SUB, 16'h0001, 16'h0002, 1'b0, 1'b0);
    chk_all("sub_1_2", 16'h00FF, 16'h00FF, 1'b1, 1'b0, 1'b1);
    apply(SUB, 16'h0001, 16'h0002, 1'b0, 1'b1);
    chk_all("sub_swap", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    apply(ADDW, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk_all("addw_wrap", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    apply(ADSW, 16'h1000, 16'h00FE, 1'b0, 1'b0);
    chk_all("adsw_neg", 16'h0FFE, 16'h0FFE, 1'b1, 1'b0, 1'b0);
    apply(RRC, 16'h0001, 16'h0000, 1'b1, 1'b0);
    chk_all("rrc", 16'h0080, 16'h0080, 1'b1, 1'b0, 1'b1);
    apply(RLC, 16'h0080, 16'h0000, 1'b0, 1'b0);
    chk_all("rlc", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    apply(SEX, 16'h0080, 16'h0000, 1'b0, 1'b0);
    chk_all("sex", 16'hFF80, 16'hFF80, 1'b0, 1'b0, 1'b1);
    apply(PASS0, 16'hxx00, 16'hxxxx, 1'b0, 1'b0);
    chk_all("pass0_x", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    apply(ADD, 16'hAB01, 16'hCD02, 1'b0, 1'b0);
    chk_all("add_upper_ignored", 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
    apply(INC, 16'h00FF, 16'h0000, 1'b0, 1'b0);
    chk_all("inc_ff", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    apply(DEC, 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk_all("dec_00", 16'h00FF, 16'h00FF, 1'b1, 1'b0, 1'b1);
    apply(SBC, 16'h0000, 16'h00FF, 1'b1, 1'b0);
    chk_all("sbc_min", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    apply(SBCW, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk_all("sbcw_borrow", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    apply(aluinst_t'(5'd27), 16'h1234, 16'h5678, 1'b1, 1'b0);
    chk_all("undef_pass0", 16'h0034, 16'h0034, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 160; i++) begin
      apply_model($sformatf("rand%0d", i), aluinst_t'(5'($urandom_range(0, 31))),
                  16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

`ifdef ALU_OUTREG_EN
    apply(ADD, 16'h0040, 16'h0001, 1'b0, 1'b0);
    chk_all("pre_reset", 16'h0041, 16'h0041, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset     = 1'b0;
    aluinst   = ADD;
    op0       = 16'h0001;
    op1       = 16'h0001;
    c_in      = 1'b0;
    swapop_in = 1'b0;
    #1;
    chk("post_reset_before_edge", result_mem, 16'h0000);
    @(posedge clk); #1;
    chk_all("post_reset_add", 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
`else
    apply(ADD, 16'h0001, 16'h0001, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_all("comb_reset_ignored", 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
